// File: rtl/loader_pkg.sv
// Shared definitions for the ROM loader/dumper pair: FSM states, frame length
// and the byte-order convention of the upload/download framing.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_LEN  = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_SEND_DATA = 3'd4
  } state_t;

  // The length header is a fixed 4-byte field.
  localparam int LEN_BYTES = 4;

  // Multi-byte quantities travel least-significant byte first.
  localparam bit LSB_FIRST = 1'b1;

  // Select byte 'lane' of a 32-bit word in transmission order.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [1:0] l;
    l = LSB_FIRST ? lane : ~lane;
    return word[{l, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rom_dumper_if.sv
// Bus bundle between the dumper, the program ROM read port and the UART
// transmitter.
//
// Handshake rules:
//  - UART side is valid/ready: a byte moves on every clk edge where
//    uart_transmitter_write_req && uart_transmitter_ready. While write_req is
//    high and ready is low, write_req and data stay stable. write_req comes
//    from a register and never depends combinationally on ready.
//  - ROM side is request/response: read_req is a one-cycle strobe, and
//    read_data_valid returns the word one or more cycles later. At most one
//    read is outstanding.
interface rom_dumper_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] program_rom_read_addr;
  logic                  program_rom_read_req;
  logic [31:0]           program_rom_read_data;
  logic                  program_rom_read_data_valid;
  logic [7:0]            uart_transmitter_data;
  logic                  uart_transmitter_write_req;
  logic                  uart_transmitter_ready;

  // Dumper side.
  modport master (
    output program_rom_read_addr,
    output program_rom_read_req,
    input  program_rom_read_data,
    input  program_rom_read_data_valid,
    output uart_transmitter_data,
    output uart_transmitter_write_req,
    input  uart_transmitter_ready
  );

  // ROM / transmitter side.
  modport slave (
    input  program_rom_read_addr,
    input  program_rom_read_req,
    output program_rom_read_data,
    output program_rom_read_data_valid,
    input  uart_transmitter_data,
    input  uart_transmitter_write_req,
    output uart_transmitter_ready
  );
endinterface

// File: rtl/rom_dumper.sv
// Streams the program ROM out over the UART: a 4-byte little-endian length
// header followed by that many ROM bytes, word 0 upward, LSB byte first.
module rom_dumper
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [31:0]  dump_len,
  output logic         busy,
  output logic         done,
  output state_t       dbg_state,
  rom_dumper_if.master bus
);

  state_t                state_q, state_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           byte_index_q, byte_index_d;
  logic [1:0]            len_index_q, len_index_d;
  logic [31:0]           word_q, word_d;
  logic                  write_req_q, write_req_d;
  logic [7:0]            data_q, data_d;
  logic                  read_req_q, read_req_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic                  done_q, done_d;

  logic        xfer;
  logic [31:0] byte_index_inc;

  assign xfer           = write_req_q && bus.uart_transmitter_ready;
  assign byte_index_inc = byte_index_q + 32'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (start) state_d = ST_SEND_LEN;
      ST_SEND_LEN:
        if (xfer && len_index_q == 2'(LEN_BYTES - 1))
          state_d = (len_q == 32'd0) ? ST_IDLE : ST_READ_REQ;
      ST_READ_REQ:
        state_d = ST_READ_WAIT;
      ST_READ_WAIT:
        if (bus.program_rom_read_data_valid) state_d = ST_SEND_DATA;
      ST_SEND_DATA:
        if (xfer) begin
          if (byte_index_inc == len_q)      state_d = ST_IDLE;
          else if (byte_index_inc[1:0] == 2'd0) state_d = ST_READ_REQ;
        end
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and word buffer.
  always_comb begin
    len_d        = len_q;
    byte_index_d = byte_index_q;
    len_index_d  = len_index_q;
    word_d       = word_q;
    write_req_d  = write_req_q;
    data_d       = data_q;
    read_addr_d  = read_addr_q;
    read_req_d   = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d        = dump_len;
          len_index_d  = 2'd0;
          byte_index_d = 32'd0;
          write_req_d  = 1'b1;
          data_d       = pick_byte(dump_len, 2'd0);
        end
      end
      ST_SEND_LEN: begin
        if (xfer) begin
          len_index_d = len_index_q + 2'd1;
          if (len_index_q == 2'(LEN_BYTES - 1)) begin
            write_req_d = 1'b0;
            if (len_q == 32'd0) begin
              done_d = 1'b1;
            end else begin
              read_req_d  = 1'b1;
              read_addr_d = byte_index_q[ADDR_WIDTH+1:2];
            end
          end else begin
            data_d = pick_byte(len_q, len_index_q + 2'd1);
          end
        end
      end
      ST_READ_WAIT: begin
        if (bus.program_rom_read_data_valid) begin
          word_d      = bus.program_rom_read_data;
          write_req_d = 1'b1;
          data_d      = bus.program_rom_read_data[7:0];
        end
      end
      ST_SEND_DATA: begin
        if (xfer) begin
          byte_index_d = byte_index_inc;
          word_d       = word_q >> 8;
          if (byte_index_inc == len_q) begin
            write_req_d = 1'b0;
            done_d      = 1'b1;
          end else if (byte_index_inc[1:0] == 2'd0) begin
            // Address wraps naturally through the truncating slice.
            write_req_d = 1'b0;
            read_req_d  = 1'b1;
            read_addr_d = byte_index_inc[ADDR_WIDTH+1:2];
          end else begin
            data_d = word_q[15:8];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything so a late ROM reply lands in IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q        <= '0;
      byte_index_q <= '0;
      len_index_q  <= '0;
      word_q       <= '0;
      write_req_q  <= 1'b0;
      data_q       <= '0;
      read_req_q   <= 1'b0;
      read_addr_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      len_q        <= len_d;
      byte_index_q <= byte_index_d;
      len_index_q  <= len_index_d;
      word_q       <= word_d;
      write_req_q  <= write_req_d;
      data_q       <= data_d;
      read_req_q   <= read_req_d;
      read_addr_q  <= read_addr_d;
      done_q       <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  assign bus.program_rom_read_addr      = read_addr_q;
  assign bus.program_rom_read_req       = read_req_q;
  assign bus.uart_transmitter_data      = data_q;
  assign bus.uart_transmitter_write_req = write_req_q;

endmodule
